// File: rtl/npu_loader_pkg.sv
// Shared types and default sizes for the NPU SRAM loaders.
package npu_loader_pkg;

  localparam int DEF_BUS_SIZE       = 32;
  localparam int DEF_WR_DAT_CYC_NUM = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [DEF_BUS_SIZE-1:0][7:0] byte_vec_t;

endpackage

// File: rtl/sparse_compactor.sv
// Combinational packer: dense beat -> sparsemap plus nonzero bytes packed from lane 0.
module sparse_compactor
  import npu_loader_pkg::*;
#(
  parameter int BUS_SIZE = DEF_BUS_SIZE
) (
  input  logic [BUS_SIZE*8-1:0] data_i,
  output logic [BUS_SIZE-1:0]   sparsemap_o,
  output logic [BUS_SIZE*8-1:0] packed_o
);

  localparam int LW = (BUS_SIZE > 1) ? $clog2(BUS_SIZE) : 1;

  logic [BUS_SIZE-1:0][7:0] bytes_c;
  logic [BUS_SIZE-1:0][7:0] lanes_c;
  logic [LW-1:0]            lane;

  assign bytes_c = data_i;

  // lane tracks the running popcount of the map below byte k
  always_comb begin
    sparsemap_o = '0;
    lanes_c     = '0;
    lane        = '0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      if (bytes_c[k] != 8'h00) begin
        sparsemap_o[k] = 1'b1;
        lanes_c[lane]  = bytes_c[k];
        lane           = lane + LW'(1);
      end
    end
  end

  assign packed_o = lanes_c;

endmodule

// File: rtl/sparse_chunk_writer.sv
// Dense-beat to sparse-chunk SRAM loader. Optional zero-byte counter under `ZERO_COUNT_EN.
module sparse_chunk_writer
  import npu_loader_pkg::*;
#(
  parameter int BUS_SIZE       = DEF_BUS_SIZE,
  parameter int WR_DAT_CYC_NUM = DEF_WR_DAT_CYC_NUM,
  parameter int CHUNK_NUM      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [$clog2(CHUNK_NUM)-1:0]   chunk_base_i,
  input  logic [$clog2(CHUNK_NUM):0]     chunk_total_i,
  input  logic                           in_valid_i,
  input  logic [BUS_SIZE*8-1:0]          in_data_i,
  output logic                           in_ready_o,
  output logic                           wr_valid_o,
  output logic [BUS_SIZE-1:0]            wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0]          wr_nonzero_data_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0] wr_dat_count_o,
  output logic [$clog2(CHUNK_NUM)-1:0]   wr_chunk_count_o,
  output logic                           busy_o,
  output logic                           done_o
`ifdef ZERO_COUNT_EN
  ,
  output logic [31:0]                    zero_cnt_o
`endif
);

  localparam int CW = $clog2(CHUNK_NUM);
  localparam int DW = $clog2(WR_DAT_CYC_NUM);

  typedef logic [CW-1:0] chunk_t;
  typedef logic [DW-1:0] dat_t;
  typedef logic [CW:0]   rem_t;

  state_e state_q, state_d;
  chunk_t chunk_cnt_q, chunk_cnt_d;
  dat_t   dat_cnt_q, dat_cnt_d;
  rem_t   rem_q, rem_d;

  logic                   accept;
  logic                   chunk_end;
  logic [BUS_SIZE-1:0]    map_c;
  logic [BUS_SIZE*8-1:0]  packed_c;

  logic                   vld_p1_q;
  logic [BUS_SIZE-1:0]    sparsemap_p1_q;
  logic [BUS_SIZE*8-1:0]  data_p1_q;
  dat_t                   dat_cnt_p1_q;
  chunk_t                 chunk_cnt_p1_q;

  sparse_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
    .data_i      (in_data_i),
    .sparsemap_o (map_c),
    .packed_o    (packed_c)
  );

  assign in_ready_o = (state_q == LOAD);
  assign accept     = in_ready_o & in_valid_i;
  assign chunk_end  = (dat_cnt_q == dat_t'(WR_DAT_CYC_NUM - 1));

  always_comb begin
    state_d     = state_q;
    chunk_cnt_d = chunk_cnt_q;
    dat_cnt_d   = dat_cnt_q;
    rem_d       = rem_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          chunk_cnt_d = chunk_base_i;
          rem_d       = chunk_total_i;
          dat_cnt_d   = '0;
          state_d     = (chunk_total_i == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (chunk_end) begin
            dat_cnt_d   = '0;
            chunk_cnt_d = (chunk_cnt_q == chunk_t'(CHUNK_NUM - 1)) ? '0 : chunk_cnt_q + chunk_t'(1);
            rem_d       = rem_q - rem_t'(1);
            if (rem_q == rem_t'(1)) state_d = DONE;
          end else begin
            dat_cnt_d = dat_cnt_q + dat_t'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      chunk_cnt_q <= '0;
      dat_cnt_q   <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      chunk_cnt_q <= chunk_cnt_d;
      dat_cnt_q   <= dat_cnt_d;
      rem_q       <= rem_d;
    end
  end

  // p1: write stage, counters captured at acceptance; data holds when idle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p1_q       <= 1'b0;
      sparsemap_p1_q <= '0;
      data_p1_q      <= '0;
      dat_cnt_p1_q   <= '0;
      chunk_cnt_p1_q <= '0;
    end else begin
      vld_p1_q <= accept;
      if (accept) begin
        sparsemap_p1_q <= map_c;
        data_p1_q      <= packed_c;
        dat_cnt_p1_q   <= dat_cnt_q;
        chunk_cnt_p1_q <= chunk_cnt_q;
      end
    end
  end

  assign wr_valid_o        = vld_p1_q;
  assign wr_sparsemap_o    = sparsemap_p1_q;
  assign wr_nonzero_data_o = data_p1_q;
  assign wr_dat_count_o    = dat_cnt_p1_q;
  assign wr_chunk_count_o  = chunk_cnt_p1_q;
  assign busy_o            = (state_q != IDLE);
  assign done_o            = (state_q == DONE);

`ifdef ZERO_COUNT_EN
  localparam int ZW = $clog2(BUS_SIZE + 1);

  logic [31:0]   zero_cnt_q;
  logic [ZW-1:0] zeros_c;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    zeros_c = '0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      if (!map_c[k]) zeros_c = zeros_c + ZW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      zero_cnt_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      zero_cnt_q <= '0;
    end else if (accept) begin
      zero_cnt_q <= sat_add(zero_cnt_q, 32'(zeros_c));
    end
  end

  assign zero_cnt_o = zero_cnt_q;
`endif

endmodule

// File: tb/tb_sparse_chunk_writer.sv
// Scoreboard bench for sparse_chunk_writer (BUS_SIZE=4, WR_DAT_CYC_NUM=4, CHUNK_NUM=16).
module tb_sparse_chunk_writer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  chunk_base_i = '0;
  logic [4:0]  chunk_total_i = '0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        in_ready_o, wr_valid_o, busy_o, done_o;
  logic [3:0]  wr_sparsemap_o;
  logic [31:0] wr_nonzero_data_o;
  logic [1:0]  wr_dat_count_o;
  logic [3:0]  wr_chunk_count_o;
`ifdef ZERO_COUNT_EN
  logic [31:0] zero_cnt_o;
`endif

  typedef struct packed {
    logic [3:0]  map;
    logic [31:0] data;
    logic [1:0]  dat;
    logic [3:0]  chunk;
  } exp_t;

  exp_t wq[$];
  bit   dq[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] tv_data[4] = '{32'h2200_1100, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0033};
  logic [3:0]  tv_map[4]  = '{4'b1010, 4'b0000, 4'b1111, 4'b0001};
  logic [31:0] tv_pack[4] = '{32'h0000_2211, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0033};

  sparse_chunk_writer #(.BUS_SIZE(4), .WR_DAT_CYC_NUM(4), .CHUNK_NUM(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .chunk_base_i      (chunk_base_i),
    .chunk_total_i     (chunk_total_i),
    .in_valid_i        (in_valid_i),
    .in_data_i         (in_data_i),
    .in_ready_o        (in_ready_o),
    .wr_valid_o        (wr_valid_o),
    .wr_sparsemap_o    (wr_sparsemap_o),
    .wr_nonzero_data_o (wr_nonzero_data_o),
    .wr_dat_count_o    (wr_dat_count_o),
    .wr_chunk_count_o  (wr_chunk_count_o),
    .busy_o            (busy_o),
    .done_o            (done_o)
`ifdef ZERO_COUNT_EN
    ,
    .zero_cnt_o        (zero_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or done.
  always @(negedge clk) begin
    if (rst_i) begin
      if (wr_valid_o) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", 64'(wr_valid_o), 64'd0);
        end else begin
          exp_t e;
          e = wq.pop_front();
          chk("wr_sparsemap", 64'(wr_sparsemap_o), 64'(e.map));
          chk("wr_data", 64'(wr_nonzero_data_o), 64'(e.data));
          chk("wr_dat_count", 64'(wr_dat_count_o), 64'(e.dat));
          chk("wr_chunk_count", 64'(wr_chunk_count_o), 64'(e.chunk));
        end
      end
      if (done_o) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 64'(done_o), 64'd0);
        end else begin
          bit f;
          f = dq.pop_front();
          chk("done_with_write", 64'(wr_valid_o), 64'(f));
        end
      end
    end
  end

  task automatic start_load(input logic [3:0] base, input logic [4:0] total);
    @(negedge clk);
    chk("ready_idle", 64'(in_ready_o), 64'd0);
    start_i = 1'b1;
    chunk_base_i = base;
    chunk_total_i = total;
    if (total == 5'd0) dq.push_back(1'b0);
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic beat(input int idx, input logic [1:0] dat, input logic [3:0] chunk, input bit last);
    exp_t e;
    @(negedge clk);
    chk("ready_load", 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b1;
    in_data_i = tv_data[idx];
    e.map = tv_map[idx];
    e.data = tv_pack[idx];
    e.dat = dat;
    e.chunk = chunk;
    wq.push_back(e);
    if (last) dq.push_back(1'b1);
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic load_chunk(input logic [3:0] chunk, input bit last);
    for (int i = 0; i < 4; i++) beat(i, 2'(i), chunk, last && (i == 3));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 64'(wq.size() + dq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd0);
    chk("rst_data", 64'(wr_nonzero_data_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b1;

    // four-beat single chunk, done with the 4th write
    start_load(4'd0, 5'd1);
    load_chunk(4'd0, 1'b1);
    drain("drain_t1");
`ifdef ZERO_COUNT_EN
    chk("zero_cnt_t1", 64'(zero_cnt_o), 64'd9);
`endif
    chk("idle_after_t1", 64'(busy_o), 64'd0);

    // chunk index wraps 14,15,0
    start_load(4'd14, 5'd3);
    load_chunk(4'd14, 1'b0);
    load_chunk(4'd15, 1'b0);
    load_chunk(4'd0, 1'b1);
    drain("drain_t2");

    // zero-chunk load
    start_load(4'd7, 5'd0);
    chk("t0_busy", 64'(busy_o), 64'd1);
    chk("t0_ready", 64'(in_ready_o), 64'd0);
    @(posedge clk);
    #1;
    chk("t0_busy_off", 64'(busy_o), 64'd0);
    drain("drain_t3");
`ifdef ZERO_COUNT_EN
    chk("zero_cnt_cleared", 64'(zero_cnt_o), 64'd0);
`endif

    // valid 1,0,0,1 with an ignored start during LOAD
    start_load(4'd3, 5'd1);
    beat(0, 2'd0, 4'd3, 1'b0);
    @(negedge clk);
    start_i = 1'b1;
    chunk_base_i = 4'd9;
    chunk_total_i = 5'd1;
    chk("stall_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    beat(1, 2'd1, 4'd3, 1'b0);
    beat(2, 2'd2, 4'd3, 1'b0);
    beat(3, 2'd3, 4'd3, 1'b1);
    drain("drain_t4");

    // asynchronous reset mid-load
    start_load(4'd2, 5'd1);
    beat(0, 2'd0, 4'd2, 1'b0);
    beat(1, 2'd1, 4'd2, 1'b0);
    @(negedge clk);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("arst_map", 64'(wr_sparsemap_o), 64'd0);
    chk("arst_data", 64'(wr_nonzero_data_o), 64'd0);
    chk("arst_dat", 64'(wr_dat_count_o), 64'd0);
    chk("arst_chunk", 64'(wr_chunk_count_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_ready", 64'(in_ready_o), 64'd0);
`ifdef ZERO_COUNT_EN
    chk("arst_zero_cnt", 64'(zero_cnt_o), 64'd0);
`endif
    @(negedge clk);
    rst_i = 1'b1;
    chk("arst_queue", 64'(wq.size()), 64'd0);
    start_load(4'd5, 5'd1);
    load_chunk(4'd5, 1'b1);
    drain("drain_t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
